// File: rtl/pot_scan_ctrl.sv
`default_nettype none
//============================================================================
//  Module      : pot_scan_ctrl
//  Description : Round-robin scan controller that shares one A2D conversion
//                engine among the six equalizer slide-pot registers. It issues
//                one conversion at a time, waits for completion or a timeout,
//                stores the raw 12-bit result and paces requests with a
//                programmable idle gap.
//  Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
//  Ports
//    clk        in   system clock
//    rst_n      in   asynchronous active-low reset
//    en         in   scan enable
//    clr_err    in   clears the sticky timeout flag
//    strt_cnv   out  one-cycle conversion request to the A2D interface
//    chnnl      out  A2D channel of the current request (registered)
//    cnv_cmplt  in   A2D conversion done, one-cycle pulse
//    res        in   A2D result, valid with cnv_cmplt
//    pot_lp     out  low-pass gain   (channel 1)
//    pot_b1     out  band1 gain      (channel 0)
//    pot_b2     out  band2 gain      (channel 4)
//    pot_b3     out  band3 gain      (channel 2)
//    pot_hp     out  high-pass gain  (channel 3)
//    volume     out  volume          (channel 7)
//    scan_done  out  one-cycle pulse after slot 5 completes or times out
//    pots_vld   out  set after the first scan finished without timeouts
//    err        out  sticky conversion timeout flag
//============================================================================
module pot_scan_ctrl #(
    parameter int GAP_CYCLES     = 1024,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr_err,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    input  logic        cnv_cmplt,
    input  logic [11:0] res,
    output logic [11:0] pot_lp,
    output logic [11:0] pot_b1,
    output logic [11:0] pot_b2,
    output logic [11:0] pot_b3,
    output logic [11:0] pot_hp,
    output logic [11:0] volume,
    output logic        scan_done,
    output logic        pots_vld,
    output logic        err
);

    // One shared timer measures both the WAIT timeout and the GAP length,
    // so it is sized for the larger of the two.
    localparam int c_MAX_CYCLES = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int c_TMR_W      = $clog2(c_MAX_CYCLES) + 1;

    localparam logic [c_TMR_W-1:0] c_TMO_LAST = c_TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_GAP_LAST = c_TMR_W'(GAP_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE  = c_TMR_W'(1);

    localparam logic [2:0] c_LAST_SLOT = 3'd5;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_GAP   = 2'd3;

    logic [1:0]         r_state;
    logic [c_TMR_W-1:0] r_timer;
    logic [2:0]         r_slot;
    logic [2:0]         r_chnnl;
    logic [11:0]        r_pot [0:5];
    logic               r_scan_done;
    logic               r_pots_vld;
    logic               r_scan_tmo;
    logic               r_err;

    logic               w_wait_cmplt;
    logic               w_wait_tmo;
    logic               w_slot_end;
    logic               w_gap_last;
    logic [2:0]         w_slot_nxt;

    // Slot -> A2D channel mapping (slot order lp, b1, b2, b3, hp, volume).
    function automatic logic [2:0] f_slot2ch(input logic [2:0] slot);
        logic [2:0] ch;
        case (slot)
            3'd0:    ch = 3'd1;
            3'd1:    ch = 3'd0;
            3'd2:    ch = 3'd4;
            3'd3:    ch = 3'd2;
            3'd4:    ch = 3'd3;
            3'd5:    ch = 3'd7;
            default: ch = 3'd1;
        endcase
        return ch;
    endfunction

    // Completion beats timeout when both land on the same cycle.
    assign w_wait_cmplt = (r_state == c_ST_WAIT) && cnv_cmplt;
    assign w_wait_tmo   = (r_state == c_ST_WAIT) && !cnv_cmplt && (r_timer == c_TMO_LAST);
    assign w_slot_end   = w_wait_cmplt || w_wait_tmo;
    assign w_gap_last   = (r_state == c_ST_GAP) && (r_timer == c_GAP_LAST);
    assign w_slot_nxt   = (r_slot == c_LAST_SLOT) ? 3'd0 : (r_slot + 3'd1);

    //------------------------------------------------------------------------
    // Sequencer: state, timer, slot pointer, channel and scan status
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_timer     <= '0;
            r_slot      <= 3'd0;
            r_chnnl     <= 3'd1;
            r_scan_done <= 1'b0;
            r_pots_vld  <= 1'b0;
            r_scan_tmo  <= 1'b0;
        end else begin
            r_scan_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (en) begin
                        r_state <= c_ST_START;
                    end
                end
                c_ST_START: begin
                    r_timer <= '0;
                    r_state <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    r_timer <= r_timer + c_TMR_ONE;
                    if (w_slot_end) begin
                        r_timer <= '0;
                        r_slot  <= w_slot_nxt;
                        r_chnnl <= f_slot2ch(w_slot_nxt);
                        r_state <= c_ST_GAP;
                        if (r_slot == c_LAST_SLOT) begin
                            // End of a scan: report it and qualify pots_vld on
                            // a scan that saw no timeouts, including this slot.
                            r_scan_done <= 1'b1;
                            r_scan_tmo  <= 1'b0;
                            if (!r_scan_tmo && !w_wait_tmo) begin
                                r_pots_vld <= 1'b1;
                            end
                        end else if (w_wait_tmo) begin
                            r_scan_tmo <= 1'b1;
                        end
                    end
                end
                c_ST_GAP: begin
                    r_timer <= r_timer + c_TMR_ONE;
                    if (w_gap_last) begin
                        r_timer <= '0;
                        r_state <= en ? c_ST_START : c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    //------------------------------------------------------------------------
    // Pot registers: raw result captured only on a completion inside WAIT
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) begin
                r_pot[i] <= 12'h000;
            end
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (w_wait_cmplt && (r_slot == 3'(i))) begin
                    r_pot[i] <= res;
                end
            end
        end
    end

    //------------------------------------------------------------------------
    // Sticky timeout flag: a new timeout overrides a same-cycle clear
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_wait_tmo) begin
            r_err <= 1'b1;
        end else if (clr_err) begin
            r_err <= 1'b0;
        end
    end

    assign strt_cnv  = (r_state == c_ST_START);
    assign chnnl     = r_chnnl;
    assign pot_lp    = r_pot[0];
    assign pot_b1    = r_pot[1];
    assign pot_b2    = r_pot[2];
    assign pot_b3    = r_pot[3];
    assign pot_hp    = r_pot[4];
    assign volume    = r_pot[5];
    assign scan_done = r_scan_done;
    assign pots_vld  = r_pots_vld;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pot_scan_ctrl.sv
`default_nettype none
//============================================================================
//  Module      : tb_pot_scan_ctrl
//  Description : Scoreboard bench for pot_scan_ctrl. Stimulus pushes the
//                expected request sequence (channel, spacing) into a queue;
//                a monitor pops and compares on every strt_cnv. An A2D model
//                answers requests and checks the captured registers.
//  Revision    : 1.0 - initial release
//============================================================================
module tb_pot_scan_ctrl;

    localparam int c_GAP = 4;
    localparam int c_TMO = 16;
    localparam int c_K   = 10;
    localparam int c_CH [6] = '{1, 0, 4, 2, 3, 7};

    logic        clk = 1'b0;
    logic        rst_n, en, clr_err, strt_cnv, cnv_cmplt;
    logic        scan_done, pots_vld, err;
    logic [2:0]  chnnl;
    logic [11:0] res;
    logic [11:0] pot_lp, pot_b1, pot_b2, pot_b3, pot_hp, volume;

    typedef struct {
        int ch;
        int per;
    } exp_t;

    exp_t        sb[$];
    int          ntests = 0;
    int          nfail  = 0;
    int          cyc = 0, last_strt = 0, strt_cnt = 0, sd_cnt = 0;
    logic [11:0] res_tab [0:7];
    logic [11:0] exp_pot [0:7];
    int          resp_k  [0:7];
    int          drop_ch = -1;
    bit          clr_on_tmo = 1'b0, clr_req = 1'b0;
    bit          exp_vld = 1'b0, scan_clean = 1'b1;
    int          stray_cnt = 0, stray_seen = 0;

    pot_scan_ctrl #(
        .GAP_CYCLES     (c_GAP),
        .TIMEOUT_CYCLES (c_TMO)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clr_err   (clr_err),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .cnv_cmplt (cnv_cmplt),
        .res       (res),
        .pot_lp    (pot_lp),
        .pot_b1    (pot_b1),
        .pot_b2    (pot_b2),
        .pot_b3    (pot_b3),
        .pot_hp    (pot_hp),
        .volume    (volume),
        .scan_done (scan_done),
        .pots_vld  (pots_vld),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int get_pot(input int ch);
        case (ch)
            1:       return int'(pot_lp);
            0:       return int'(pot_b1);
            4:       return int'(pot_b2);
            2:       return int'(pot_b3);
            3:       return int'(pot_hp);
            7:       return int'(volume);
            default: return -1;
        endcase
    endfunction

    task automatic push(input int ch, input int per);
        exp_t e;
        e.ch  = ch;
        e.per = per;
        sb.push_back(e);
    endtask

    task automatic push_scan(input int first_per);
        for (int i = 0; i < 6; i++) begin
            push(c_CH[i], (i == 0) ? first_per : 1 + c_K + c_GAP);
        end
    endtask

    task automatic wait_sd(input int n, input int budget);
        int i = 0;
        while (sd_cnt < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("wait_scan_done", (sd_cnt >= n) ? 1 : 0, 1);
    endtask

    task automatic wait_strt(input int n, input int budget);
        int i = 0;
        while (strt_cnt < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("wait_strt_cnv", (strt_cnv_seen(n)) ? 1 : 0, 1);
    endtask

    function automatic bit strt_cnv_seen(input int n);
        return strt_cnt >= n;
    endfunction

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < 6; i++) begin
            chk({tag, "_pot"}, get_pot(c_CH[i]), 0);
        end
        chk({tag, "_strt_cnv"},  int'(strt_cnv),  0);
        chk({tag, "_chnnl"},     int'(chnnl),     1);
        chk({tag, "_scan_done"}, int'(scan_done), 0);
        chk({tag, "_pots_vld"},  int'(pots_vld),  0);
        chk({tag, "_err"},       int'(err),       0);
    endtask

    // Monitor: every request is matched against the scoreboard queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n === 1'b1 && strt_cnv === 1'b1) begin
                strt_cnt++;
                if (sb.size() == 0) begin
                    chk("strt_unexpected", int'(chnnl), -1);
                end else begin
                    e = sb.pop_front();
                    chk("chnnl", int'(chnnl), e.ch);
                    if (e.per != 0) begin
                        chk("strt_period", cyc - last_strt, e.per);
                    end
                end
                last_strt = cyc;
            end
            if (scan_done === 1'b1) begin
                sd_cnt++;
            end
        end
    end

    // A2D model: answers each request after resp_k cycles (or never, for the
    // dropped channel) and checks the register the cycle after completion.
    initial begin
        int  m_cnt = 0, m_ch = 0, m_k = 0;
        bit  m_busy = 1'b0, m_drop = 1'b0, m_pend = 1'b0, clr_pulse;
        cnv_cmplt = 1'b0;
        res       = 12'h000;
        clr_err   = 1'b0;
        forever begin
            @(negedge clk);
            cnv_cmplt = 1'b0;
            res       = 12'($urandom);
            clr_pulse = 1'b0;
            if (rst_n !== 1'b1) begin
                m_busy     = 1'b0;
                m_pend     = 1'b0;
                exp_vld    = 1'b0;
                scan_clean = 1'b1;
                for (int i = 0; i < 8; i++) exp_pot[i] = 12'h000;
            end else begin
                if (m_pend) begin
                    m_pend = 1'b0;
                    chk("pot_capture", get_pot(m_ch), int'(exp_pot[m_ch]));
                    chk("scan_done",   int'(scan_done), (m_ch == 7) ? 1 : 0);
                    chk("pots_vld",    int'(pots_vld), int'(exp_vld));
                    if (m_k == c_TMO) chk("err_boundary_cmplt", int'(err), 0);
                end
                if (m_busy) begin
                    m_cnt++;
                    if (!m_drop && m_cnt == m_k) begin
                        cnv_cmplt     = 1'b1;
                        res           = res_tab[m_ch];
                        exp_pot[m_ch] = res_tab[m_ch];
                        m_pend        = 1'b1;
                        m_busy        = 1'b0;
                        if (m_ch == 7) begin
                            if (scan_clean) exp_vld = 1'b1;
                            scan_clean = 1'b1;
                        end
                    end else if (m_drop && m_cnt == c_TMO) begin
                        chk("err_before_tmo", int'(err), 0);
                        if (clr_on_tmo) clr_pulse = 1'b1;
                    end else if (m_drop && m_cnt == c_TMO + 1) begin
                        chk("err_tmo", int'(err), 1);
                        chk("pot_tmo_unchanged", get_pot(m_ch), int'(exp_pot[m_ch]));
                        chk("scan_done_tmo", int'(scan_done), (m_ch == 7) ? 1 : 0);
                        scan_clean = (m_ch == 7);
                        m_busy     = 1'b0;
                    end
                end
                if (strt_cnv === 1'b1) begin
                    m_busy = 1'b1;
                    m_cnt  = 0;
                    m_ch   = int'(chnnl);
                    m_drop = (m_ch == drop_ch);
                    m_k    = resp_k[m_ch];
                end
                if (stray_cnt != stray_seen) begin
                    stray_seen = stray_cnt;
                    cnv_cmplt  = 1'b1;
                    res        = 12'h5A5;
                end
            end
            clr_err = clr_req | clr_pulse;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Stimulus
    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        for (int i = 0; i < 8; i++) resp_k[i] = c_K;
        res_tab[1] = 12'hA5A; res_tab[0] = 12'h123; res_tab[4] = 12'h456;
        res_tab[2] = 12'h789; res_tab[3] = 12'hBCD; res_tab[7] = 12'hFE1;
        res_tab[5] = 12'h000; res_tab[6] = 12'h000;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Two clean scans, new values for the second one.
        push_scan(0);
        push_scan(1 + c_K + c_GAP);
        en = 1'b1;
        wait_sd(1, 200);
        chk("pots_vld_scan1", int'(pots_vld), 1);
        res_tab[1] = 12'h3C1; res_tab[0] = 12'h0F0; res_tab[4] = 12'h842;
        res_tab[2] = 12'h2D7; res_tab[3] = 12'h61E; res_tab[7] = 12'h9B4;
        wait_sd(2, 200);
        for (int i = 0; i < 6; i++) begin
            chk("pot_scan2", get_pot(c_CH[i]), int'(res_tab[c_CH[i]]));
        end
        chk("scan_done_count", sd_cnt, 2);

        // Scan 3: channel 4 never answers.
        drop_ch = 4;
        push(1, 15); push(0, 15); push(4, 15);
        push(2, 1 + c_TMO + c_GAP); push(3, 15); push(7, 15);
        wait_sd(3, 300);
        chk("err_after_scan3", int'(err), 1);
        chk("pot_b2_kept", int'(pot_b2), 12'h842);

        // Scan 4: completion on the timeout cycle, then clear racing a timeout.
        drop_ch    = 2;
        resp_k[4]  = c_TMO;
        clr_on_tmo = 1'b1;
        push(1, 15); push(0, 15); push(4, 15);
        push(2, 1 + c_TMO + c_GAP); push(3, 1 + c_TMO + c_GAP); push(7, 15);
        clr_req = 1'b1;
        repeat (2) @(negedge clk);
        clr_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("err_cleared", int'(err), 0);
        wait_sd(4, 300);
        chk("err_clr_vs_tmo", int'(err), 1);
        drop_ch    = -1;
        resp_k[4]  = c_K;
        clr_on_tmo = 1'b0;

        // Scan 5: drop en while channel 3 converts, then resume.
        push(1, 15); push(0, 15); push(4, 15); push(2, 15); push(3, 15);
        wait_strt(29, 200);
        repeat (3) @(negedge clk);
        en = 1'b0;
        repeat (60) @(negedge clk);
        chk("idle_no_strt", strt_cnt, 29);
        chk("idle_chnnl", int'(chnnl), 7);
        push(7, 0); push(1, 15);
        en = 1'b1;
        wait_strt(31, 100);

        // Reset in the middle of channel 1's conversion, then a stray completion.
        repeat (3) @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state("mid_reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        stray_cnt++;
        repeat (5) @(negedge clk);
        check_reset_state("stray");
        chk("stray_no_strt", strt_cnt, 31);
        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire
